// File: rtl/rv_enc_pkg.sv
// Shared types and pure encoding helpers for the RV32I instruction encoder.
// Op numbering matches the IR decoder so the two blocks stay interchangeable.
package rv_enc_pkg;

    localparam logic [5:0] LastOp = 6'd36;

    typedef enum logic [5:0] {
        OpAdd = 6'd0, OpSub, OpSll, OpSlt, OpSltu, OpXor, OpSrl, OpSra, OpOr, OpAnd,
        OpAddi, OpSlti, OpSltiu, OpXori, OpSlli, OpSrli, OpSrai, OpOri, OpAndi,
        OpLb, OpLh, OpLw, OpLbu, OpLhu, OpSb, OpSh, OpSw, OpLui, OpAuipc,
        OpBeq, OpBne, OpBlt, OpBge, OpBltu, OpBgeu, OpJal, OpJalr
    } op_e;

    typedef enum logic [2:0] {FmtR, FmtI, FmtSh, FmtLd, FmtS, FmtB, FmtU, FmtJ} fmt_e;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    localparam logic [6:0] OpcOp     = 7'b0110011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;

    localparam logic [6:0] F7Base = 7'b0000000;
    localparam logic [6:0] F7Alt  = 7'b0100000;

    function automatic fmt_e op_to_format(input logic [5:0] op);
        fmt_e fmt;
        if (op <= 6'd9)                      fmt = FmtR;
        else if (op >= 6'd14 && op <= 6'd16) fmt = FmtSh;
        else if (op <= 6'd18)                fmt = FmtI;
        else if (op <= 6'd23)                fmt = FmtLd;
        else if (op <= 6'd26)                fmt = FmtS;
        else if (op <= 6'd28)                fmt = FmtU;
        else if (op <= 6'd34)                fmt = FmtB;
        else if (op == 6'd35)                fmt = FmtJ;
        else                                 fmt = FmtI;
        return fmt;
    endfunction

    function automatic logic [6:0] op_opcode(input logic [5:0] op);
        logic [6:0] opc;
        case (op_to_format(op))
            FmtR:         opc = OpcOp;
            FmtI, FmtSh:  opc = (op == OpJalr) ? OpcJalr : OpcOpImm;
            FmtLd:        opc = OpcLoad;
            FmtS:         opc = OpcStore;
            FmtB:         opc = OpcBranch;
            FmtU:         opc = (op == OpLui) ? OpcLui : OpcAuipc;
            FmtJ:         opc = OpcJal;
            default:      opc = 7'b0000000;
        endcase
        return opc;
    endfunction

    function automatic logic [2:0] op_funct3(input logic [5:0] op);
        logic [2:0] f3;
        case (op)
            OpSll, OpSlli, OpLh, OpSh, OpBne:             f3 = 3'b001;
            OpSlt, OpSlti, OpLw, OpSw:                    f3 = 3'b010;
            OpSltu, OpSltiu:                              f3 = 3'b011;
            OpXor, OpXori, OpLbu, OpBlt:                  f3 = 3'b100;
            OpSrl, OpSra, OpSrli, OpSrai, OpLhu, OpBge:   f3 = 3'b101;
            OpOr, OpOri, OpBltu:                          f3 = 3'b110;
            OpAnd, OpAndi, OpBgeu:                        f3 = 3'b111;
            default:                                      f3 = 3'b000;
        endcase
        return f3;
    endfunction

    function automatic logic [6:0] op_funct7(input logic [5:0] op);
        return (op == OpSub || op == OpSra || op == OpSrai) ? F7Alt : F7Base;
    endfunction

    // Returns 1 when imm fits the format's immediate field without truncation.
    function automatic logic imm_in_range(input fmt_e fmt, input logic [31:0] imm);
        logic signed [31:0] s;
        logic ok;
        s = $signed(imm);
        case (fmt)
            FmtI, FmtLd, FmtS: ok = (s >= -32'sd2048) && (s <= 32'sd2047);
            FmtSh:             ok = (imm[31:5] == 27'd0);
            FmtB:              ok = (s >= -32'sd4096) && (s <= 32'sd4094) && !imm[0];
            FmtJ:              ok = (s >= -32'sd1048576) && (s <= 32'sd1048575) && !imm[0];
            FmtU:              ok = (imm[11:0] == 12'd0);
            default:           ok = 1'b1;
        endcase
        return ok;
    endfunction

    function automatic logic [31:0] encode_word(input logic [5:0] op, input logic [4:0] rd,
                                                input logic [4:0] rs1, input logic [4:0] rs2,
                                                input logic [31:0] imm);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] w;
        opc = op_opcode(op);
        f3  = op_funct3(op);
        f7  = op_funct7(op);
        case (op_to_format(op))
            FmtR:        w = {f7, rs2, rs1, f3, rd, opc};
            FmtI, FmtLd: w = {imm[11:0], rs1, f3, rd, opc};
            FmtSh:       w = {f7, imm[4:0], rs1, f3, rd, opc};
            FmtS:        w = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
            FmtB:        w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
            FmtU:        w = {imm[31:12], rd, opc};
            FmtJ:        w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
            default:     w = 32'd0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head read; DEPTH must be a power of two.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW:0]    wr_ptr_q, rd_ptr_q;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign pop_data = mem_q[rd_ptr_q[PtrW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push && !full)  wr_ptr_q <= wr_ptr_q + (PtrW+1)'(1);
            if (pop && !empty)  rd_ptr_q <= rd_ptr_q + (PtrW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) mem_q[wr_ptr_q[PtrW-1:0]] <= push_data;
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs decoder-style op/register/immediate requests into RV32I words and streams them,
// with incrementing word addresses, to the instruction-memory loader.
module instr_encoder
    import rv_enc_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              done,
    output logic              err_illegal,
    output logic              err_range,
    output logic [15:0]       count
);

    localparam logic [ADDR_W-1:0] AddrAlign = ~ADDR_W'(3);
    localparam logic [ADDR_W-1:0] WordStep  = ADDR_W'(4);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       count_q, count_d;
    logic              err_illegal_q, err_illegal_d;
    logic              err_range_q, err_range_d;

    logic        fifo_full, fifo_empty;
    logic        accept, legal, push, pop, range_ok, start_go;
    logic [31:0] enc_word;
    fmt_e        fmt;

    assign legal    = (in_op <= LastOp);
    assign fmt      = op_to_format(in_op);
    assign enc_word = encode_word(in_op, in_rd, in_rs1, in_rs2, in_imm);
    assign range_ok = imm_in_range(fmt, in_imm);

    assign in_ready  = (state_q == StRun) && !fifo_full;
    assign accept    = in_valid && in_ready;
    // Illegal ops complete the handshake but never reach the FIFO.
    assign push      = accept && legal;
    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign start_go  = (state_q == StIdle) && start;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (enc_word),
        .pop       (pop),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (accept && in_last) state_d = StDrain;
            StDrain: if (fifo_empty) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        addr_d        = addr_q;
        count_d       = count_q;
        err_illegal_d = err_illegal_q;
        err_range_d   = err_range_q;
        if (start_go) begin
            addr_d        = base_addr & AddrAlign;
            count_d       = 16'd0;
            err_illegal_d = 1'b0;
            err_range_d   = 1'b0;
        end else begin
            if (pop) begin
                addr_d = addr_q + WordStep;
                if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
            end
            if (accept && !legal)             err_illegal_d = 1'b1;
            if (accept && legal && !range_ok) err_range_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            addr_q        <= '0;
            count_q       <= 16'd0;
            err_illegal_q <= 1'b0;
            err_range_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            count_q       <= count_d;
            err_illegal_q <= err_illegal_d;
            err_range_q   <= err_range_d;
        end
    end

    assign out_addr    = addr_q;
    assign count       = count_q;
    assign err_illegal = err_illegal_q;
    assign err_range   = err_range_q;
    assign done        = (state_q == StDone);

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: expected words queued at accept, compared at take.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset, start, in_valid, in_ready, in_last;
    logic [31:0] base_addr, in_imm, out_data, out_addr;
    logic [5:0]  in_op;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic        out_valid, out_ready, done, err_illegal, err_range;
    logic [15:0] count;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_addr;
    logic [15:0] exp_count;

    instr_encoder #(
        .DEPTH  (4),
        .ADDR_W (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .base_addr   (base_addr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_rd       (in_rd),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .in_imm      (in_imm),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_addr    (out_addr),
        .done        (done),
        .err_illegal (err_illegal),
        .err_range   (err_range),
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: a word is taken at the coming posedge.
    task automatic take_word();
        logic [31:0] w;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL spurious_word: observed=%h expected=no word", out_data);
        end
        if (exp_q.size() != 0) begin
            w = exp_q.pop_front();
            chk("out_data", out_data, w);
        end
        chk("out_addr", out_addr, exp_addr);
        exp_addr  = exp_addr + 32'd4;
        exp_count = exp_count + 16'd1;
    endtask

    task automatic step(output bit acc);
        @(negedge clk);
        acc = in_valid && in_ready;
        if (out_valid && out_ready) take_word();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        bit a;
        step(a);
    endtask

    task automatic send(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [31:0] imm, input bit last,
                        input logic [31:0] exp_word, input bit legal);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_op    = op;
        in_rd    = rd;
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_imm   = imm;
        in_last  = last;
        for (int i = 0; i < 20 && !acc; i++) step(acc);
        checks++;
        assert (acc) else begin
            errors++;
            $error("FAIL handshake_timeout: observed=no accept expected=accept of op %0d", op);
        end
        if (acc && legal) exp_q.push_back(exp_word);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        tick();
        chk("scoreboard_empty", exp_q.size(), 32'd0);
    endtask

    task automatic do_start(input logic [31:0] base);
        start     = 1'b1;
        base_addr = base;
        tick();
        start     = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; in_valid = 1'b0; in_last = 1'b0;
        in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0; out_ready = 1'b1;
        exp_addr = '0; exp_count = '0;
        repeat (3) tick();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_err_illegal", err_illegal, 0);
        chk("rst_err_range", err_range, 0);
        chk("rst_count", count, 0);
        chk("rst_out_addr", out_addr, 0);
        reset = 1'b0;
        tick();

        // Program 1: basic encodings, latency, range error.
        do_start(32'h100);
        exp_addr = 32'h100; exp_count = 0;
        chk("run_in_ready", in_ready, 1);
        send(6'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 32'h003100B3, 1'b1);
        chk("latency_out_valid", out_valid, 1);
        send(6'd10, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 32'hFFF00293, 1'b1);
        send(6'd27, 5'd1, 5'd0, 5'd0, 32'h12345000, 1'b0, 32'h123450B7, 1'b1);
        send(6'd29, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 32'h00208463, 1'b1);
        chk("err_range_clear", err_range, 0);
        send(6'd29, 5'd0, 5'd1, 5'd2, 32'd7, 1'b0, 32'h00208363, 1'b1);
        chk("err_range_odd_branch", err_range, 1);
        drain();
        chk("count_p1", count, exp_count);

        // Backpressure: fill the FIFO, then release.
        out_ready = 1'b0;
        send(6'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 32'h003100B3, 1'b1);
        send(6'd10, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 32'hFFF00293, 1'b1);
        send(6'd27, 5'd1, 5'd0, 5'd0, 32'h12345000, 1'b0, 32'h123450B7, 1'b1);
        send(6'd29, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, 32'h00208463, 1'b1);
        chk("full_in_ready", in_ready, 0);
        chk("full_out_addr", out_addr, exp_addr);
        out_ready = 1'b1;
        drain();
        chk("count_bp", count, exp_count);

        // Illegal op carrying in_last ends the program with nothing pushed.
        send(6'd40, 5'd1, 5'd1, 5'd1, 32'd0, 1'b1, 32'd0, 1'b0);
        chk("err_illegal_set", err_illegal, 1);
        chk("illegal_no_push", out_valid, 0);
        chk("illegal_done_early", done, 0);
        tick();
        chk("illegal_done_pulse", done, 1);
        tick();
        chk("illegal_done_end", done, 0);
        chk("idle_in_ready", in_ready, 0);
        chk("illegal_count", count, exp_count);
        chk("illegal_addr", out_addr, exp_addr);

        // Program 2: fresh start clears state, base low bits dropped, mid-run start ignored.
        do_start(32'h2003);
        exp_addr = 32'h2000; exp_count = 0;
        chk("p2_err_illegal", err_illegal, 0);
        chk("p2_err_range", err_range, 0);
        chk("p2_count", count, 0);
        chk("p2_base_aligned", out_addr, 32'h2000);
        send(6'd26, 5'd0, 5'd2, 5'd5, 32'd8, 1'b0, 32'h00512423, 1'b1);
        do_start(32'h5000);
        chk("start_ignored_count", count, exp_count);
        send(6'd35, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 32'h001000EF, 1'b1);
        send(6'd16, 5'd1, 5'd2, 5'd0, 32'd3, 1'b1, 32'h40315093, 1'b1);
        chk("p2_done_pre", done, 0);
        tick();
        chk("p2_done_taken", done, 0);
        tick();
        chk("p2_done_pulse", done, 1);
        tick();
        chk("p2_done_end", done, 0);
        chk("p2_count_final", count, 16'd3);
        chk("p2_scoreboard", exp_q.size(), 32'd0);

        // Program 3: reset with words queued flushes everything.
        do_start(32'h40);
        exp_addr = 32'h40; exp_count = 0;
        out_ready = 1'b0;
        send(6'd0, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 32'h003100B3, 1'b1);
        send(6'd1, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0, 32'h403100B3, 1'b1);
        chk("p3_queued", out_valid, 1);
        reset = 1'b1;
        tick();
        exp_q.delete();
        chk("p3_rst_out_valid", out_valid, 0);
        chk("p3_rst_in_ready", in_ready, 0);
        chk("p3_rst_count", count, 0);
        chk("p3_rst_done", done, 0);
        reset = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("p3_post_out_valid", out_valid, 0);
        chk("p3_post_done", done, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
